// File: rtl/bqm_pkg.sv
// Shared types, display table and helpers for the bank-queue controller.
package bqm_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Active-low 7-segment patterns, a..g on bits 6..0, digits 0-F.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Truncated to the wait-time width at the point of use.
  localparam logic [31:0] WAIT_NO_SERVICE = '1;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/bqm_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one sensor.
module bqm_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_p
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs only while the synchronised level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign rise_p = rise_q;

endmodule

// File: rtl/bank_queue_ctrl.sv
// Bank queue controller: people/teller counts, wait estimate via restoring divider.
// Optional BQM_SEG7_EN adds registered 7-segment outputs seg_p / seg_t.
module bank_queue_ctrl
  import bqm_pkg::*;
#(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned N_TELLERS    = 3,
  parameter int unsigned TELLER_W     = 2,
  parameter int unsigned SERVICE_T    = 3,
  parameter int unsigned WT_W         = 5,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sensor_in,
  input  logic                         sensor_out,
  input  logic [N_TELLERS-1:0]         teller_sw,
  output logic [CNT_W-1:0]             p_count,
  output logic [TELLER_W-1:0]          t_count,
  output logic                         full,
  output logic                         empty,
  output logic                         err_ovf,
  output logic                         err_unf,
  output logic [WT_W-1:0]              wait_time,
  output logic                         wait_valid,
  output logic [TELLER_W+CNT_W-1:0]    con
`ifdef BQM_SEG7_EN
  ,
  output logic [6:0]                   seg_p,
  output logic [6:0]                   seg_t
`endif
);
  localparam int unsigned IW = $clog2(WT_W);

  logic                 enter_p, leave_p;
  logic [N_TELLERS-1:0] tsync1_q, tsync2_q;
  logic [CNT_W-1:0]     p_q, p_d, last_p_q, last_p_d;
  logic [TELLER_W-1:0]  t_q, t_d, last_t_q, last_t_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  div_state_e           state_q, state_d;
  logic [WT_W-1:0]      dvd_q, dvd_d, wt_q, wt_d, num;
  logic [TELLER_W-1:0]  rem_q, rem_d, dsr_q, dsr_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic                 wv_q, wv_d;
  logic [TELLER_W:0]    rem_sh;
  logic                 ge;

  bqm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_in (
    .clk(clk), .reset(reset), .async_in(sensor_in), .rise_p(enter_p)
  );
  bqm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_out (
    .clk(clk), .reset(reset), .async_in(sensor_out), .rise_p(leave_p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tsync1_q <= '0;
      tsync2_q <= '0;
      p_q      <= '0;
      t_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      state_q  <= DIV_IDLE;
      last_p_q <= '0;
      last_t_q <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      iter_q   <= '0;
      wt_q     <= '0;
      wv_q     <= 1'b1;
    end else begin
      tsync1_q <= teller_sw;
      tsync2_q <= tsync1_q;
      p_q      <= p_d;
      t_q      <= t_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      state_q  <= state_d;
      last_p_q <= last_p_d;
      last_t_q <= last_t_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      iter_q   <= iter_d;
      wt_q     <= wt_d;
      wv_q     <= wv_d;
    end
  end

  // Saturating people count; simultaneous entry and exit cancel.
  always_comb begin
    p_d   = p_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    t_d   = TELLER_W'(popcount(32'(tsync2_q)));
    if (enter_p && !leave_p) begin
      if (full) ovf_d = 1'b1;
      else      p_d   = p_q + CNT_W'(1);
    end else if (leave_p && !enter_p) begin
      if (empty) unf_d = 1'b1;
      else       p_d   = p_q - CNT_W'(1);
    end
  end

  // Divider: any (P,T) change restarts it, so no stale quotient is ever written.
  always_comb begin
    state_d  = state_q;
    last_p_d = last_p_q;
    last_t_d = last_t_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    iter_d   = iter_q;
    wt_d     = wt_q;
    wv_d     = wv_q;
    num      = WT_W'(SERVICE_T) * (WT_W'(p_q) + WT_W'(t_q) - WT_W'(1));
    rem_sh   = {rem_q, dvd_q[WT_W-1]};
    ge       = (rem_sh >= {1'b0, dsr_q});
    if (p_q != last_p_q || t_q != last_t_q) begin
      last_p_d = p_q;
      last_t_d = t_q;
      if (p_q == '0) begin
        wt_d    = '0;
        wv_d    = 1'b1;
        state_d = DIV_IDLE;
      end else if (t_q == '0) begin
        wt_d    = WT_W'(WAIT_NO_SERVICE);
        wv_d    = 1'b1;
        state_d = DIV_IDLE;
      end else begin
        dvd_d   = num;
        rem_d   = '0;
        dsr_d   = t_q;
        iter_d  = '0;
        wv_d    = 1'b0;
        state_d = DIV_CALC;
      end
    end else begin
      case (state_q)
        DIV_CALC: begin
          rem_d  = ge ? TELLER_W'(rem_sh - {1'b0, dsr_q}) : TELLER_W'(rem_sh);
          dvd_d  = {dvd_q[WT_W-2:0], ge};
          iter_d = iter_q + IW'(1);
          if (iter_q == IW'(WT_W - 1)) begin
            wt_d    = {dvd_q[WT_W-2:0], ge};
            wv_d    = 1'b1;
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  assign p_count    = p_q;
  assign t_count    = t_q;
  assign full       = &p_q;
  assign empty      = ~|p_q;
  assign err_ovf    = ovf_q;
  assign err_unf    = unf_q;
  assign wait_time  = wt_q;
  assign wait_valid = wv_q;
  assign con        = {t_q, p_q};

`ifdef BQM_SEG7_EN
  logic [6:0] seg_p_q, seg_p_d, seg_t_q, seg_t_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p_q <= 7'b0000001;
      seg_t_q <= 7'b0000001;
    end else begin
      seg_p_q <= seg_p_d;
      seg_t_q <= seg_t_d;
    end
  end

  always_comb begin
    seg_p_d = SEG7_LUT[4'(p_q)];
    seg_t_d = SEG7_LUT[4'(t_q)];
  end

  assign seg_p = seg_p_q;
  assign seg_t = seg_t_q;
`endif

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Self-checking bench for bank_queue_ctrl (default parameters).
module tb_bank_queue_ctrl;
  logic       clk;
  logic       reset;
  logic       sensor_in, sensor_out;
  logic [2:0] teller_sw;
  logic [2:0] p_count;
  logic [1:0] t_count;
  logic       full, empty, err_ovf, err_unf, wait_valid;
  logic [4:0] wait_time;
  logic [4:0] con;
`ifdef BQM_SEG7_EN
  logic [6:0] seg_p, seg_t;
`endif

  bank_queue_ctrl dut (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .sensor_out(sensor_out),
    .teller_sw(teller_sw), .p_count(p_count), .t_count(t_count), .full(full),
    .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf), .wait_time(wait_time),
    .wait_valid(wait_valid), .con(con)
`ifdef BQM_SEG7_EN
    , .seg_p(seg_p), .seg_t(seg_t)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int model_p = 0;
  bit model_ovf = 0, model_unf = 0;
  bit settled = 0;
  int stable = 0;
  int low_cnt = 0;
  logic [2:0] prev_sw = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_wait(input int p, input int t);
    if (p == 0) return 0;
    if (t == 0) return 31;
    return 3 * (p + t - 1) / t;
  endfunction

  function automatic logic [6:0] seg7(input int v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  default: return 7'b1111111;
    endcase
  endfunction

  // Compare process: checks outputs against the model whenever they must be settled.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      stable = 0;
      prev_sw = teller_sw;
    end else begin
      if (!wait_valid) low_cnt++;
      if (teller_sw != prev_sw) stable = 0;
      else if (stable < 1000) stable++;
      prev_sw = teller_sw;
      if (settled) begin
        chk("p_count", 32'(p_count), 32'(model_p));
        chk("full", 32'(full), 32'(model_p == 7));
        chk("empty", 32'(empty), 32'(model_p == 0));
        chk("err_ovf", 32'(err_ovf), 32'(model_ovf));
        chk("err_unf", 32'(err_unf), 32'(model_unf));
      end
      if (stable >= 3) chk("t_count", 32'(t_count), 32'($countones(teller_sw)));
      if (settled && stable >= 3) begin
        chk("con", 32'(con), 32'($countones(teller_sw) * 8 + model_p));
        if (wait_valid)
          chk("wait_time", 32'(wait_time), 32'(exp_wait(model_p, $countones(teller_sw))));
`ifdef BQM_SEG7_EN
        chk("seg_p", 32'(seg_p), 32'(seg7(model_p)));
        chk("seg_t", 32'(seg_t), 32'(seg7($countones(teller_sw))));
`endif
      end
    end
  end

  // Raw sensor pulse of 'hi' cycles, then a quiet gap; the model follows the counting rules.
  task automatic pulse(input bit ent, input bit ext, input int hi);
    @(negedge clk);
    settled = 0;
    sensor_in = ent;
    sensor_out = ext;
    repeat (hi) @(negedge clk);
    sensor_in = 1'b0;
    sensor_out = 1'b0;
    repeat (12) @(negedge clk);
    if (hi > 4) begin
      if (ent && !ext) begin
        if (model_p == 7) model_ovf = 1;
        else model_p++;
      end else if (ext && !ent) begin
        if (model_p == 0) model_unf = 1;
        else model_p--;
      end
    end
    settled = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    settled = 0;
    model_p = 0;
    model_ovf = 0;
    model_unf = 0;
    @(posedge clk);
    #2;
    chk("rst_p", 32'(p_count), 32'd0);
    chk("rst_t", 32'(t_count), 32'd0);
    chk("rst_wait", 32'(wait_time), 32'd0);
    chk("rst_valid", 32'(wait_valid), 32'd1);
    chk("rst_ovf", 32'(err_ovf), 32'd0);
    chk("rst_unf", 32'(err_unf), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
`ifdef BQM_SEG7_EN
    chk("rst_seg_p", 32'(seg_p), 32'h01);
`endif
    @(negedge clk);
    reset = 1'b0;
    settled = 1;
  endtask

  task automatic wait_valid_low(input string name);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (!wait_valid) seen = 1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    bit saw7, done;
    reset = 1'b1;
    sensor_in = 1'b0;
    sensor_out = 1'b0;
    teller_sw = 3'b000;
    repeat (3) @(negedge clk);
    do_reset();

    // 1: three clean entries with one teller
    teller_sw = 3'b001;
    repeat (8) @(negedge clk);
    pulse(1, 0, 6);
    pulse(1, 0, 6);
    low_cnt = 0;
    pulse(1, 0, 6);
    chk("t1_p", 32'(p_count), 32'd3);
    chk("t1_con", 32'(con), 32'b01_011);
    chk("t1_low_cycles", 32'(low_cnt), 32'd5);
    chk("t1_wait", 32'(wait_time), 32'd9);
    chk("t1_valid", 32'(wait_valid), 32'd1);
`ifdef BQM_SEG7_EN
    chk("t1_seg_p", 32'(seg_p), 32'b0000110);
`endif

    // 2: short glitch is rejected
    low_cnt = 0;
    pulse(1, 0, 2);
    chk("t2_p", 32'(p_count), 32'd3);
    chk("t2_no_recalc", 32'(low_cnt), 32'd0);

    // 3: fill and overflow
    repeat (4) pulse(1, 0, 6);
    chk("t3_p7", 32'(p_count), 32'd7);
    pulse(1, 0, 6);
    chk("t3_p_hold", 32'(p_count), 32'd7);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(err_ovf), 32'd1);
    pulse(0, 1, 6);
    chk("t3_p6", 32'(p_count), 32'd6);
    chk("t3_ovf_sticky", 32'(err_ovf), 32'd1);

    // 4: underflow, then simultaneous entry/exit when full
    repeat (6) pulse(0, 1, 6);
    pulse(0, 1, 6);
    chk("t4_p0", 32'(p_count), 32'd0);
    chk("t4_unf", 32'(err_unf), 32'd1);
    do_reset();
    repeat (7) pulse(1, 0, 6);
    pulse(1, 1, 6);
    chk("t4_both_p", 32'(p_count), 32'd7);
    chk("t4_both_ovf", 32'(err_ovf), 32'd0);
    chk("t4_both_unf", 32'(err_unf), 32'd0);

    // 5: teller change mid-divide restarts the estimate
    repeat (3) pulse(0, 1, 6);
    chk("t5_p4", 32'(p_count), 32'd4);
    @(negedge clk);
    teller_sw = 3'b011;
    wait_valid_low("t5_calc_start");
    @(negedge clk);
    teller_sw = 3'b111;
    saw7 = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #2;
      if (wait_time == 5'd7) saw7 = 1;
      if (wait_valid && t_count == 2'd3) done = 1;
    end
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_no_stale", 32'(saw7), 32'd0);
    chk("t5_wait", 32'(wait_time), 32'd6);

    // 6: no tellers, then reset during a divide
    pulse(1, 0, 6);
    @(negedge clk);
    teller_sw = 3'b000;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #2;
      if (t_count == 2'd0) done = 1;
    end
    chk("t6_t0_seen", 32'(done), 32'd1);
    @(posedge clk);
    #2;
    chk("t6_valid", 32'(wait_valid), 32'd1);
    chk("t6_wait", 32'(wait_time), 32'h1F);
    @(negedge clk);
    teller_sw = 3'b001;
    wait_valid_low("t6_calc_start");
    do_reset();
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
